// File: rtl/counter_sequencer.sv
// counter_sequencer: run-control sequencer for a WIDTH-bit wrapping up-counter
// Ports: clk/rst_n clock and async active-low reset; cfg_valid_i/cfg_ready_o
// config handshake carrying cfg_period_i and cfg_oneshot_i; start_i, pause_i,
// stop_i run controls; count_o current count; tick_o wrap pulse; done_o
// one-shot completion pulse; busy_o high while running or held.
module counter_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] cfg_period_i,
  input  logic             cfg_oneshot_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             stop_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic             done_o,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, period_q, period_d, eff_period;
  logic oneshot_q, oneshot_d, tick_q, tick_d, done_q, done_d, cfg_fire, wrap;
  assign cfg_ready_o = state_q == IDLE;
  assign cfg_fire    = cfg_valid_i && cfg_ready_o;
  // a config word landing on the START edge supplies the period used for that run
  assign eff_period  = cfg_fire ? cfg_period_i : period_q;
  assign wrap        = count_q == period_q - WIDTH'(1);
  assign count_o     = count_q;
  assign tick_o      = tick_q;
  assign done_o      = done_q;
  assign busy_o      = state_q != IDLE;
  // HOLD with pause released counts on that same edge, so each paused
  // cycle delays the next wrap by exactly one cycle
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = eff_period;
    oneshot_d = cfg_fire ? cfg_oneshot_i : oneshot_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    if (state_q == IDLE) begin
      if (start_i && eff_period != '0) begin
        state_d = RUN;
        count_d = '0;
      end
    end else if (stop_i) begin
      state_d = IDLE;
      count_d = '0;
    end else if (pause_i) begin
      state_d = HOLD;
    end else if (wrap) begin
      count_d = '0;
      tick_d  = 1'b1;
      done_d  = oneshot_q;
      state_d = oneshot_q ? IDLE : RUN;
    end else begin
      count_d = count_q + WIDTH'(1);
      state_d = RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      period_q  <= '0;
      oneshot_q <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      oneshot_q <= oneshot_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed and random checks of two widths against an elapsed-cycle model
module tb_counter_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_oneshot = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [7:0] cfg_period = '0;
  logic rdy8, tick8, done8, busy8, rdy2, tick2, done2, busy2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  int tests = 0, fails = 0;
  int w[2] = '{8, 2};
  int m_busy[2], m_n[2], m_p[2], m_os[2], m_tick[2], m_done[2];
  always #5 clk = ~clk;
  counter_sequencer #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(rdy8),
    .cfg_period_i(cfg_period), .cfg_oneshot_i(cfg_oneshot), .start_i(start),
    .pause_i(pause), .stop_i(stop), .count_o(cnt8), .tick_o(tick8),
    .done_o(done8), .busy_o(busy8));
  counter_sequencer #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(rdy2),
    .cfg_period_i(cfg_period[1:0]), .cfg_oneshot_i(cfg_oneshot), .start_i(start),
    .pause_i(pause), .stop_i(stop), .count_o(cnt2), .tick_o(tick2),
    .done_o(done2), .busy_o(busy2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int exp_cnt(int i);
    return m_busy[i] != 0 ? m_n[i] % m_p[i] : 0;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_n[i] = 0; m_p[i] = 0; m_os[i] = 0; m_tick[i] = 0; m_done[i] = 0;
    end
  endtask
  // n counts active (unpaused) edges since start; a wrap is every P-th one
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int effp;
      m_tick[i] = 0;
      m_done[i] = 0;
      if (m_busy[i] == 0) begin
        effp = cfg_valid ? (int'(cfg_period) % (1 << w[i])) : m_p[i];
        if (cfg_valid) begin
          m_p[i] = effp;
          m_os[i] = int'(cfg_oneshot);
        end
        if (start && effp != 0) begin
          m_busy[i] = 1;
          m_n[i] = 0;
        end
      end else if (stop) begin
        m_busy[i] = 0;
        m_n[i] = 0;
      end else if (!pause) begin
        m_n[i]++;
        if (m_n[i] % m_p[i] == 0) begin
          m_tick[i] = 1;
          if (m_os[i] != 0) begin
            m_busy[i] = 0;
            m_done[i] = 1;
            m_n[i] = 0;
          end
        end
      end
    end
  endtask
  task automatic check_all();
    chk("count_w8", 32'(cnt8), exp_cnt(0));
    chk("tick_w8", 32'(tick8), m_tick[0]);
    chk("done_w8", 32'(done8), m_done[0]);
    chk("busy_w8", 32'(busy8), m_busy[0]);
    chk("ready_w8", 32'(rdy8), 32'(m_busy[0] == 0));
    chk("count_w2", 32'(cnt2), exp_cnt(1));
    chk("tick_w2", 32'(tick2), m_tick[1]);
    chk("done_w2", 32'(done2), m_done[1]);
    chk("busy_w2", 32'(busy2), m_busy[1]);
    chk("ready_w2", 32'(rdy2), 32'(m_busy[1] == 0));
  endtask
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic cfg_start(input int p, input logic os);
    cfg_valid = 1'b1; cfg_period = 8'(p); cfg_oneshot = os; start = 1'b1;
    cycle();
    cfg_valid = 1'b0; start = 1'b0;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cfg_start(3, 1'b0);
    repeat (10) cycle();
    cfg_valid = 1'b1; cfg_period = 8'd5; cfg_oneshot = 1'b1;
    repeat (3) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    cycle();
    cfg_valid = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (7) cycle();
    cfg_start(4, 1'b0);
    repeat (2) cycle();
    pause = 1'b1;
    repeat (2) cycle();
    pause = 1'b0;
    repeat (9) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    cfg_start(3, 1'b0);
    repeat (2) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    repeat (2) cycle();
    cfg_start(1, 1'b1);
    repeat (2) cycle();
    cfg_start(1, 1'b0);
    repeat (4) cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_all();
    for (int k = 0; k < 600; k++) begin
      cfg_valid   = ($urandom_range(0, 3) == 0);
      cfg_period  = 8'($urandom_range(0, 9));
      cfg_oneshot = 1'($urandom_range(0, 1));
      start       = ($urandom_range(0, 3) == 0);
      pause       = ($urandom_range(0, 4) == 0);
      stop        = ($urandom_range(0, 15) == 0);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Run-control sequencer for a WIDTH-bit up-counter datapath (adder plus register). It accepts a period and mode over a valid/ready configuration port and starts, pauses and stops the count. It emits a one-cycle TICK each time the count wraps, and a DONE pulse when a one-shot run completes. It sits between a host/control FSM and the counter datapath, and acts as the shared programmable timer for downstream blocks.

## Interface
- WIDTH, default 8: counter and period width in bits; must be ≥ 1.
- CLK  in  1  single clock; all state updates on the rising edge.
- RESETN  in  1  reset; asynchronous, active-low.
- CFG_VALID  in  1  configuration word valid.
- CFG_READY  out  1  configuration accepted this cycle if CFG_VALID; combinational, equals (state == IDLE).
- CFG_PERIOD  in  WIDTH  period P in cycles; legal range 1..2^WIDTH-1.
- CFG_ONESHOT  in  1  1 = stop after first wrap, 0 = periodic.
- START  in  1  level-sampled start request.
- PAUSE  in  1  level; while high, the count is held.
- STOP  in  1  abort request; highest priority.
- COUNT  out  WIDTH  current count, registered.
- TICK  out  1  registered one-cycle wrap pulse.
- DONE  out  1  registered one-cycle pulse at one-shot completion.
- BUSY  out  1  registered; 1 in RUN or HOLD.

## Operation
- Internal registers: period_reg (WIDTH bits), oneshot_reg, state ∈ {IDLE, RUN, HOLD}.
- Reset values: state IDLE, COUNT 0, period_reg 0, oneshot_reg 0, TICK 0, DONE 0, BUSY 0, CFG_READY 1.
- Configuration: on an edge with CFG_VALID & CFG_READY, load period_reg ← CFG_PERIOD and oneshot_reg ← CFG_ONESHOT. Configuration is never accepted in RUN or HOLD; CFG_VALID is held off, with no loss of the request.
- IDLE → RUN: on START when the effective period ≠ 0. If a config handshake and START coincide, the new CFG_PERIOD is the effective period and is used. COUNT ← 0.
- START with effective period 0 is ignored; the block stays in IDLE.
- START in RUN or HOLD is ignored.
- RUN, PAUSE = 0, COUNT ≠ P-1: COUNT ← COUNT+1 (modulo 2^WIDTH adder, carry discarded); TICK ← 0.
- RUN, PAUSE = 0, COUNT = P-1 (wrap): COUNT ← 0 and TICK ← 1. If oneshot_reg = 1, also state ← IDLE and DONE ← 1.
- RUN → HOLD: on PAUSE = 1. COUNT is held and no TICK is issued.
- HOLD → RUN: on PAUSE = 0. Counting resumes from the held COUNT on the next edge.
- STOP in RUN or HOLD: state ← IDLE, COUNT ← 0, TICK 0, DONE 0. STOP beats a coincident wrap, PAUSE or START.
- STOP in IDLE has no effect.
- P = 1: COUNT stays 0 and TICK is high every RUN cycle. In one-shot mode, a single TICK and DONE occur together one cycle after start.
- COUNT never exceeds P-1, so the 2^WIDTH overflow cannot occur for legal P.
- Async reset mid-run: all registers return to reset values immediately. No TICK or DONE is emitted.

## Timing
- START sampled at edge k in IDLE: BUSY = 1 and COUNT = 0 from edge k.
- The first TICK is visible after edge k+P, unpaused. Subsequent TICKs follow every P cycles.
- Each paused cycle delays the next TICK by one cycle.
- TICK, DONE, COUNT and BUSY change only on clock edges or async reset. TICK and DONE are high for exactly one cycle.
- DONE coincides with the final TICK. BUSY falls on that same edge. CFG_READY rises in the same cycle.
- New START is accepted in the cycle after DONE. There is no back-to-back restart on the DONE edge.

## Test plan
- Reset then CFG P=3 periodic, START: COUNT goes 0,1,2,0,1,2…; TICK high on each COUNT=0 after the first, at cycles 3, 6, 9 after START; DONE stays 0.
- CFG P=5 one-shot, START: exactly one TICK plus DONE 5 cycles after START; BUSY falls with it; CFG_READY = 1 next cycle; no further TICK.
- P=4 periodic, PAUSE high for 2 cycles at COUNT=2: COUNT holds 2 and BUSY stays 1; TICK arrives 2 cycles late; period then returns to 4.
- STOP asserted on the same edge as a wrap (COUNT=P-1): no TICK, no DONE; COUNT=0, BUSY=0, CFG_READY=1.
- CFG_VALID held in RUN: CFG_READY=0 and period_reg unchanged; handshake completes on first IDLE cycle; START with period 0 after reset is ignored.
- WIDTH=2, P=3 and P=1 periodic: counts 0..2 with no overflow; P=1 gives TICK every cycle; RESETN low mid-run clears all outputs asynchronously.
